// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: instruction fetch port, data port and the
// single-port synchronous memory behind them.
// slave  : the arbiter's view (takes requests, drives the memory).
// master : the environment's view (requesters plus memory model).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  // instruction fetch port
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  // data port
  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [31:0]           d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  // memory port
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, data) for one single-port synchronous memory
// with 1-cycle read latency. Data wins ties; every grant gets exactly one
// rvalid on the following cycle, routed by a response-owner register.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN to let fetch win
// after STARVE_LIMIT consecutive denials. Without it data has strict priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} resp_e;

  resp_e state_q, state_d;
  logic  resp_we_q, resp_we_d;   // owner of RESP_D was a write -> rdata 0
  logic  fetch_win;
  logic  if_gnt, d_gnt;
  logic  starve_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign starve_force = (starve_q == CW'(STARVE_LIMIT));

  // Count consecutive fetch denials, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt)
      starve_d = '0;
    else if (starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end
`else
  assign starve_force = 1'b0;
`endif

  // Address bits outside the word index are deliberately dropped
  logic unused_addr;
  assign unused_addr = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_WIDTH+2],
                         bus.d_addr[1:0],  bus.d_addr[31:ADDR_WIDTH+2]};

  // Grant decision: data first unless fetch has been starved too long
  always_comb begin
    fetch_win = bus.if_req && (!bus.d_req || starve_force);
    if_gnt    = !rst && fetch_win;
    d_gnt     = !rst && bus.d_req && !fetch_win;
  end

  // Drive the memory from whichever requester won this cycle
  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = if_gnt || d_gnt;
    bus.mem_we    = (d_gnt && bus.d_we) ? bus.d_be : 4'b0000;
    bus.mem_addr  = if_gnt ? bus.if_addr[ADDR_WIDTH+1:2]
                           : bus.d_addr[ADDR_WIDTH+1:2];
    bus.mem_wdata = bus.d_wdata;
  end

  // Next response owner follows the grant made this cycle
  always_comb begin
    state_d   = IDLE;
    resp_we_d = 1'b0;
    if (if_gnt) begin
      state_d = RESP_I;
    end else if (d_gnt) begin
      state_d   = RESP_D;
      resp_we_d = bus.d_we;
    end
  end

  // Response-owner FSM and starvation counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      resp_we_q <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      resp_we_q <= resp_we_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

  // Route the memory read word to the response owner only
  always_comb begin
    bus.if_rvalid = !rst && (state_q == RESP_I);
    bus.d_rvalid  = !rst && (state_q == RESP_D);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = (bus.d_rvalid && !resp_we_q) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory sits on the
// memory port, a reference model predicts grants and memory contents, and
// predicted responses are queued at grant time and compared one cycle later.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 4;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mem_clear = 1'b1;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, 1-cycle read latency, byte writes
  logic [31:0] sim_mem [1024];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) sim_mem[i] <= 32'(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) sim_mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= sim_mem[bus.mem_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [1024];
  resp_t       sb [$];
  int          cnt;
  int          n_vec;
  int          n_err;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic step(output bit g_i, output bit g_d, output bit obs_ig);
    bit          fw, pend, en;
    resp_t       e, n;
    logic [9:0]  ia, da, ea;
    logic [3:0]  ewe;
    @(negedge clk);
    ia = bus.if_addr[11:2];
    da = bus.d_addr[11:2];
    fw  = bus.if_req && (!bus.d_req || (GUARD && cnt == LIMIT));
    g_i = !rst && fw;
    g_d = !rst && bus.d_req && !fw;
    en  = g_i || g_d;
    ewe = (g_d && bus.d_we) ? bus.d_be : 4'b0000;
    ea  = g_i ? ia : da;
    obs_ig = bus.if_gnt;

    pend = 1'b0;
    e.is_d = 1'b0;
    e.data = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      pend = 1'b1;
    end

    chk_eq("if_gnt",    64'(bus.if_gnt),    64'(g_i));
    chk_eq("d_gnt",     64'(bus.d_gnt),     64'(g_d));
    chk_eq("mem_en",    64'(bus.mem_en),    64'(en));
    chk_eq("mem_we",    64'(bus.mem_we),    64'(ewe));
    if (en) chk_eq("mem_addr", 64'(bus.mem_addr), 64'(ea));
    if (ewe != 4'b0000) chk_eq("mem_wdata", 64'(bus.mem_wdata), 64'(bus.d_wdata));
    chk_eq("if_rvalid", 64'(bus.if_rvalid), 64'(!rst && pend && !e.is_d));
    chk_eq("d_rvalid",  64'(bus.d_rvalid),  64'(!rst && pend && e.is_d));
    chk_eq("if_rdata",  64'(bus.if_rdata),  (!rst && pend && !e.is_d) ? 64'(e.data) : 64'h0);
    chk_eq("d_rdata",   64'(bus.d_rdata),   (!rst && pend && e.is_d) ? 64'(e.data) : 64'h0);
    chk_eq("rv_excl",   64'(bus.if_rvalid && bus.d_rvalid), 64'h0);

    if (g_i) begin
      n.is_d = 1'b0;
      n.data = ref_mem[ia];
      sb.push_back(n);
      $display("t=%0t fetch  addr=%h word=%h", $time, bus.if_addr, ia);
    end else if (g_d) begin
      n.is_d = 1'b1;
      n.data = bus.d_we ? 32'h0 : ref_mem[da];
      sb.push_back(n);
      if (bus.d_we)
        for (int b = 0; b < 4; b++)
          if (bus.d_be[b]) ref_mem[da][8*b +: 8] = bus.d_wdata[8*b +: 8];
      $display("t=%0t data %s addr=%h word=%h be=%h wdata=%h", $time,
               bus.d_we ? "wr" : "rd", bus.d_addr, da, bus.d_be, bus.d_wdata);
    end

    @(posedge clk);
    if (rst) begin
      cnt = 0;
      sb.delete();
    end else if (!bus.if_req || g_i) begin
      cnt = 0;
    end else if (cnt < LIMIT) begin
      cnt++;
    end
    mem_clear = 1'b0;
    #1;
  endtask

  task automatic idle_bus();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'h0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  initial begin
    bit gi, gd, oi, ip, dp;
    int fcount;
    n_vec = 0;
    n_err = 0;
    cnt   = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);
    idle_bus();

    // Reset with a fetch request present: no grants allowed
    rst = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    repeat (3) step(gi, gd, oi);
    rst = 1'b0;
    idle_bus();
    step(gi, gd, oi);

    // Fetch-only burst at 0x10, 0x14, 0x18 (words 4, 5, 6)
    for (int i = 0; i < 3; i++) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10 + 32'(4 * i);
      step(gi, gd, oi);
      chk_eq("burst_gnt", 64'(oi), 64'h1);
    end
    idle_bus();
    step(gi, gd, oi);

    // Partial write then read-back of 0x20
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'h3;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'hDEADBEEF;
    step(gi, gd, oi);
    bus.d_we    = 1'b0;
    step(gi, gd, oi);
    idle_bus();
    step(gi, gd, oi);
    chk_eq("merge_mem", 64'(ref_mem[8]), 64'h0000BEEF);

    // Both requesters held continuously
    fcount = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h80;
    for (int i = 0; i < 22; i++) begin
      step(gi, gd, oi);
      if (oi) fcount++;
    end
    chk_eq("starve_fetches", 64'(fcount), GUARD ? 64'd4 : 64'd0);

    // Reset mid-stream with both still requesting; counter must restart
    rst = 1'b1;
    step(gi, gd, oi);
    rst = 1'b0;
    fcount = 0;
    for (int i = 0; i < 5; i++) begin
      step(gi, gd, oi);
      if (oi) fcount++;
    end
    chk_eq("post_rst_fetches", 64'(fcount), GUARD ? 64'd1 : 64'd0);
    idle_bus();
    step(gi, gd, oi);

    // Fetch granted, then reset in the response cycle and the next
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    step(gi, gd, oi);
    rst = 1'b1;
    step(gi, gd, oi);
    step(gi, gd, oi);
    rst = 1'b0;
    idle_bus();
    step(gi, gd, oi);
    // Out-of-range byte address wraps to word 0
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1003;
    step(gi, gd, oi);
    idle_bus();
    step(gi, gd, oi);

    // Random traffic; each requester holds until granted
    ip = 1'b0;
    dp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_be    = 4'($urandom_range(0, 15));
        bus.d_addr  = $urandom_range(0, 255);
        bus.d_wdata = $urandom;
      end
      bus.if_req = ip;
      bus.d_req  = dp;
      step(gi, gd, oi);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end
    idle_bus();
    step(gi, gd, oi);
    step(gi, gd, oi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
